// File: rtl/pixel_unpacker.sv
// AXI4-Stream receiver that unpacks 4 RGB888 pixels from every 3 32-bit words and
// emits one pixel per beat with x/y position, frame markers and sticky framing errors.
module pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    input  logic        err_clr,
    output logic        sof_err,
    output logic        eol_err,
    output logic        keep_err,
    output logic [15:0] frame_count
);
    localparam int WPL  = 3 * X_SIZE / 4;
    localparam int WC_W = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [WC_W-1:0] WC_END = WC_W'(WPL - 1);
    localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
    localparam logic [9:0]      X_END  = 10'(X_SIZE - 1);
    localparam logic [8:0]      Y_END  = 9'(Y_SIZE - 1);

    if ((X_SIZE % 4) != 0) begin : g_xsize_check
        $error("pixel_unpacker: X_SIZE must be a multiple of 4");
    end

    typedef enum logic [0:0] {ST_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [23:0]     res_q, res_d;
    logic [9:0]      x_q, x_d;
    logic [8:0]      y_q, y_d;
    logic [WC_W-1:0] wc_q, wc_d;
    logic [23:0]     pix_q, pix_d;
    logic            pix_valid_q, pix_valid_d;
    logic            sof_q, sof_d, eol_q, eol_d;
    logic [9:0]      px_q, px_d;
    logic [8:0]      py_q, py_d;
    logic            sof_err_q, sof_err_d, eol_err_q, eol_err_d, keep_err_q, keep_err_d;
    logic [15:0]     frame_q, frame_d;

    logic            load_s, tready_s, accept_s, emit_s, early_s;
    logic [1:0]      wphase_s;
    logic [WC_W-1:0] wc_s;
    logic [9:0]      ex_s;
    logic [8:0]      ey_s;
    logic [23:0]     emit_pix_s;

    // Next-state: word unpacking, position tracking and error detection
    always_comb begin
        load_s      = !pix_valid_q || pix_ready;
        tready_s    = aresetn && ((state_q == ST_SYNC) || (load_s && (phase_q != 2'd3)));
        accept_s    = in_stream_tvalid && tready_s;
        state_d     = state_q;
        phase_d     = phase_q;
        res_d       = res_q;
        x_d         = x_q;
        y_d         = y_q;
        wc_d        = wc_q;
        pix_d       = pix_q;
        pix_valid_d = pix_valid_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        px_d        = px_q;
        py_d        = py_q;
        frame_d     = frame_q;
        sof_err_d   = sof_err_q && !err_clr;
        eol_err_d   = eol_err_q && !err_clr;
        keep_err_d  = keep_err_q && !err_clr;
        emit_s      = 1'b0;
        early_s     = 1'b0;
        emit_pix_s  = 24'h0;
        wphase_s    = phase_q;
        wc_s        = wc_q;
        ex_s        = x_q;
        ey_s        = y_q;

        if (accept_s && (in_stream_tkeep != 4'hF)) begin
            keep_err_d = 1'b1;
        end else begin
            keep_err_d = keep_err_d;
        end

        if (accept_s && (in_stream_tuser || (state_q == ST_RUN))) begin
            // A tuser word always restarts the frame; it is only an error mid-group or mid-frame
            if (in_stream_tuser) begin
                if ((state_q == ST_RUN) && !((phase_q == 2'd0) && (x_q == 10'd0) && (y_q == 9'd0))) begin
                    sof_err_d = 1'b1;
                end else begin
                    sof_err_d = sof_err_d;
                end
                state_d  = ST_RUN;
                wphase_s = 2'd0;
                wc_s     = '0;
                ex_s     = 10'd0;
                ey_s     = 9'd0;
            end else begin
                state_d = state_q;
            end
            emit_s = 1'b1;
            case (wphase_s)
                2'd0: begin
                    emit_pix_s = in_stream_tdata[23:0];
                    res_d      = {16'h0, in_stream_tdata[31:24]};
                    phase_d    = 2'd1;
                end
                2'd1: begin
                    emit_pix_s = {in_stream_tdata[15:0], res_q[7:0]};
                    res_d      = {8'h0, in_stream_tdata[31:16]};
                    phase_d    = 2'd2;
                end
                2'd2: begin
                    emit_pix_s = {in_stream_tdata[7:0], res_q[15:0]};
                    res_d      = in_stream_tdata[31:8];
                    phase_d    = 2'd3;
                end
                default: begin
                    emit_pix_s = res_q;
                    res_d      = 24'h0;
                    phase_d    = 2'd0;
                end
            endcase
            early_s = in_stream_tlast && (wc_s != WC_END);
            if (early_s || (!in_stream_tlast && (wc_s == WC_END))) begin
                eol_err_d = 1'b1;
            end else begin
                eol_err_d = eol_err_d;
            end
            wc_d = (early_s || (wc_s == WC_END)) ? '0 : (wc_s + WC_ONE);
        end else if ((state_q == ST_RUN) && load_s && (phase_q == 2'd3)) begin
            emit_s     = 1'b1;
            emit_pix_s = res_q;
            phase_d    = 2'd0;
        end else begin
            emit_s = 1'b0;
        end

        if (emit_s) begin
            pix_d       = emit_pix_s;
            pix_valid_d = 1'b1;
            px_d        = ex_s;
            py_d        = ey_s;
            sof_d       = (ex_s == 10'd0) && (ey_s == 9'd0);
            eol_d       = (ex_s == X_END);
            // A short line drops the rest of its group and starts the next line
            if (early_s) begin
                x_d     = 10'd0;
                y_d     = (ey_s == Y_END) ? 9'd0 : (ey_s + 9'd1);
                phase_d = 2'd0;
                res_d   = 24'h0;
            end else if (ex_s == X_END) begin
                x_d = 10'd0;
                if (ey_s == Y_END) begin
                    y_d     = 9'd0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    y_d = ey_s + 9'd1;
                end
            end else begin
                x_d = ex_s + 10'd1;
                y_d = ey_s;
            end
        end else if (load_s) begin
            pix_valid_d = 1'b0;
        end else begin
            pix_valid_d = pix_valid_q;
        end
    end

    // State, output register and sticky flag update with synchronous reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_SYNC;
            phase_q     <= 2'd0;
            res_q       <= 24'h0;
            x_q         <= 10'd0;
            y_q         <= 9'd0;
            wc_q        <= '0;
            pix_q       <= 24'h0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            px_q        <= 10'd0;
            py_q        <= 9'd0;
            sof_err_q   <= 1'b0;
            eol_err_q   <= 1'b0;
            keep_err_q  <= 1'b0;
            frame_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            res_q       <= res_d;
            x_q         <= x_d;
            y_q         <= y_d;
            wc_q        <= wc_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            px_q        <= px_d;
            py_q        <= py_d;
            sof_err_q   <= sof_err_d;
            eol_err_q   <= eol_err_d;
            keep_err_q  <= keep_err_d;
            frame_q     <= frame_d;
        end
    end

    assign in_stream_tready = tready_s;
    assign pix_r            = pix_q[23:16];
    assign pix_g            = pix_q[15:8];
    assign pix_b            = pix_q[7:0];
    assign pix_valid        = pix_valid_q;
    assign pix_sof          = sof_q;
    assign pix_eol          = eol_q;
    assign pix_x            = px_q;
    assign pix_y            = py_q;
    assign sof_err          = sof_err_q;
    assign eol_err          = eol_err_q;
    assign keep_err         = keep_err_q;
    assign frame_count      = frame_q;
endmodule
